dds_phase_core: RTL and testbench

- Waveform core that sits directly downstream of the axi_dds AXI4-Lite register file.
- Takes the committed tuning word, phase offset and control word, runs a phase accumulator, and converts phase to amplitude (quarter-wave sine LUT, sawtooth, square, triangle).
- Streams samples on an AXI4-Stream master with full backpressure.
- Returns a sample counter that the register file exposes for readback.

---
 rtl/dds_phase_core.sv | 178 +++++++++++++++++
 tb/tb_dds_phase_core.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_core.sv
// dds_phase_core: phase accumulator and 3-stage phase-to-amplitude pipeline on AXI4-Stream.
// Optional LFSR phase dither is built in when DDS_DITHER_EN is defined.
module dds_phase_core #(
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 10,
    parameter int OUT_W   = 16
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic [PHASE_W-1:0] cfg_ftw,
    input  logic [PHASE_W-1:0] cfg_poff,
    input  logic [31:0]        cfg_ctrl,
    input  logic               cfg_commit,
    output logic [OUT_W-1:0]   m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [31:0]        sample_cnt
);

    localparam int LUT_N = 1 << LUT_AW;
    localparam int PW    = LUT_AW + 2;
    localparam int FS    = (1 << (OUT_W - 1)) - 1;
    localparam logic [OUT_W-1:0] FULL = OUT_W'(FS);
    localparam logic [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};
    localparam real PI = 3.14159265358979323846;

    function automatic logic [OUT_W-2:0] lut_val(input int i);
        real ang;
        ang = PI / 2.0 * (real'(i) + 0.5) / real'(LUT_N);
        return (OUT_W-1)'($rtoi(real'(FS) * $sin(ang) + 0.5));
    endfunction

    logic [OUT_W-2:0] lut_rom [LUT_N];

    for (genvar i = 0; i < LUT_N; i++) begin : g_lut
        localparam logic [OUT_W-2:0] V = lut_val(i);
        assign lut_rom[i] = V;
    end

    logic [PHASE_W-1:0] ftw;
    logic [PHASE_W-1:0] poff;
    logic [PHASE_W-1:0] acc;
    logic               en;
    logic [1:0]         wave;
    logic               ce;
    logic               inject;
    logic [PHASE_W-1:0] inj_phase;

    logic               s1_valid;
    logic [PHASE_W-1:0] s1_phase;
    logic [1:0]         s1_wave;

    logic               s2_valid;
    logic [1:0]         s2_wave;
    logic               s2_sign;
    logic [OUT_W:0]     s2_top;
    logic [OUT_W-2:0]   lut_q;

    logic [PW-1:0]      p;
    logic [LUT_AW-1:0]  addr;
    logic [OUT_W-1:0]   fold;
    logic [OUT_W-1:0]   tri_v;
    logic [OUT_W-1:0]   lut_s;
    logic [OUT_W-1:0]   wave_v;
    logic               unused_bits;

    assign ce     = !m_axis_tvalid || m_axis_tready;
    assign inject = ce && en;

`ifdef DDS_DITHER_EN
    localparam int DW = PHASE_W - LUT_AW - 2;
    logic [31:0] lfsr;

    assign inj_phase = acc + poff + PHASE_W'(lfsr[DW-1:0]);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            lfsr <= 32'h0000_0001;
        end else if (inject) begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 32'h8020_0003) : (lfsr >> 1);
        end
    end
`else
    assign inj_phase = acc + poff;
`endif

    // commit writes come last so a phase reset overrides the increment
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ftw      <= '0;
            poff     <= '0;
            en       <= 1'b0;
            wave     <= '0;
            acc      <= '0;
            s1_valid <= 1'b0;
            s1_phase <= '0;
            s1_wave  <= '0;
        end else begin
            if (ce) begin
                s1_valid <= en;
            end
            if (inject) begin
                s1_phase <= inj_phase;
                s1_wave  <= wave;
                acc      <= acc + ftw;
            end
            if (cfg_commit) begin
                ftw  <= cfg_ftw;
                poff <= cfg_poff;
                en   <= cfg_ctrl[0];
                wave <= cfg_ctrl[2:1];
                if (cfg_ctrl[3]) begin
                    acc <= '0;
                end
            end
        end
    end

    assign p    = s1_phase[PHASE_W-1 -: PW];
    assign addr = p[LUT_AW] ? ~p[LUT_AW-1:0] : p[LUT_AW-1:0];

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            s2_valid <= 1'b0;
            s2_wave  <= '0;
            s2_sign  <= 1'b0;
            s2_top   <= '0;
            lut_q    <= '0;
        end else if (ce) begin
            s2_valid <= s1_valid;
            s2_wave  <= s1_wave;
            s2_sign  <= p[PW-1];
            s2_top   <= s1_phase[PHASE_W-1 -: OUT_W+1];
            lut_q    <= lut_rom[addr];
        end
    end

    always_comb begin
        fold   = s2_top[OUT_W] ? ~s2_top[OUT_W-1:0] : s2_top[OUT_W-1:0];
        tri_v  = {~fold[OUT_W-1], fold[OUT_W-2:0]};
        lut_s  = {1'b0, lut_q};
        wave_v = '0;
        if (tri_v == MINV) begin
            tri_v = -FULL;
        end
        unique case (s2_wave)
            2'b00: wave_v = s2_sign ? -lut_s : lut_s;
            2'b01: wave_v = {~s2_top[OUT_W], s2_top[OUT_W-1:1]};
            2'b10: wave_v = s2_top[OUT_W] ? -FULL : FULL;
            2'b11: wave_v = tri_v;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (ce) begin
            m_axis_tvalid <= s2_valid;
            if (s2_valid) begin
                m_axis_tdata <= wave_v;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            sample_cnt <= '0;
        end else if (cfg_commit && cfg_ctrl[3]) begin
            sample_cnt <= '0;
        end else if (m_axis_tvalid && m_axis_tready) begin
            sample_cnt <= sample_cnt + 32'd1;
        end
    end

    assign unused_bits = ^{cfg_ctrl[31:4], s1_phase[PHASE_W-OUT_W-2:0]};

endmodule

// File: tb/tb_dds_phase_core.sv
// Self-checking bench for dds_phase_core: directed sequence plus randomized configs
// checked against a sample-level reference of the phase/waveform rules.
module tb_dds_phase_core;

    localparam real PI = 3.14159265358979323846;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] cfg_ftw;
    logic [31:0] cfg_poff;
    logic [31:0] cfg_ctrl;
    logic        cfg_commit;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] sample_cnt;

    always #5 ACLK = ~ACLK;

    dds_phase_core dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .cfg_ftw       (cfg_ftw),
        .cfg_poff      (cfg_poff),
        .cfg_ctrl      (cfg_ctrl),
        .cfg_commit    (cfg_commit),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .sample_cnt    (sample_cnt)
    );

    typedef struct {
        logic [31:0] ph;
        logic [1:0]  wave;
        logic [31:0] acc_next;
    } smp_t;

    smp_t        exp_q[$];
    int          got[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] g_acc, g_ftw, g_poff;
    logic [1:0]  g_wave;
    int          g_n;
    int          hs;
    bit          hold_chk;
    logic [15:0] held;
    int          seen;
    int          sine_tab[4];

    task automatic chk(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // expected sample from the phase that enters the converter
    function automatic int ref_val(input logic [31:0] ph, input logic [1:0] w);
        real v;
        int  t, f;
        if (w == 2'd0) begin
            v = 32767.0 * $sin(2.0 * PI * (real'(ph >> 20) + 0.5) / 4096.0);
            return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        end
        if (w == 2'd1) return int'(ph >> 16) - 32768;
        if (w == 2'd2) return ph[31] ? -32767 : 32767;
        t = int'(ph >> 15);
        f = (t < 65536) ? t : 131071 - t;
        return (f - 32768 < -32767) ? -32767 : f - 32768;
    endfunction

    task automatic push(input int n);
        smp_t e;
        for (int i = 0; i < n; i++) begin
            e.ph       = g_acc + g_poff;
            e.wave     = g_wave;
            g_acc      = g_acc + g_ftw;
            e.acc_next = g_acc;
            exp_q.push_back(e);
            g_n++;
        end
    endtask

    // only the samples already in the pipeline survive a reconfiguration
    task automatic keep(input int k);
        while (exp_q.size() > k) begin
            void'(exp_q.pop_back());
            g_n--;
        end
        g_acc = exp_q[exp_q.size()-1].acc_next;
    endtask

    task automatic cyc(input bit rdy);
        smp_t e;
        m_axis_tready = rdy;
        if (hold_chk) begin
            chk("hold_valid", m_axis_tvalid, 1);
            chk("hold_data", m_axis_tdata, held);
        end
        hold_chk = 0;
        if (m_axis_tvalid && rdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_sample", m_axis_tvalid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sample", $signed(m_axis_tdata), ref_val(e.ph, e.wave));
            end
            got.push_back(int'($signed(m_axis_tdata)));
            hs++;
        end else if (m_axis_tvalid) begin
            hold_chk = 1;
            held     = m_axis_tdata;
        end
        @(posedge ACLK);
        #1;
    endtask

    task automatic commit(input logic [31:0] f, input logic [31:0] p, input logic [31:0] c);
        cfg_ftw    = f;
        cfg_poff   = p;
        cfg_ctrl   = c;
        cfg_commit = 1'b1;
        cyc(1'b1);
        cfg_commit = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int guard;
        commit(g_ftw, g_poff, {29'd0, g_wave, 1'b0});
        keep(3);
        guard = 0;
        while (m_axis_tvalid && guard < 40) begin
            cyc(rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            guard++;
        end
        chk("drain_tvalid", m_axis_tvalid, 0);
        chk("drain_cnt", sample_cnt, g_n);
    endtask

    task automatic run_cfg(input logic [31:0] f, input logic [31:0] p,
                           input logic [1:0] w, input int n, input bit rnd);
        g_ftw  = f;
        g_poff = p;
        g_wave = w;
        g_acc  = '0;
        g_n    = 0;
        exp_q.delete();
        got.delete();
        push(n + 20);
        commit(f, p, {28'd0, 1'b1, w, 1'b1});
        hs = 0;
        chk("cfg_cnt0", sample_cnt, 0);
        repeat (n) cyc(rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
        drain(rnd);
    endtask

    initial begin
        sine_tab = '{25, 32767, -25, -32767};
        ARESET        = 1'b1;
        cfg_ftw       = '0;
        cfg_poff      = '0;
        cfg_ctrl      = '0;
        cfg_commit    = 1'b0;
        m_axis_tready = 1'b0;
        hold_chk      = 0;
        hs            = 0;
        g_n           = 0;
        repeat (3) @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_cnt", sample_cnt, 0);
        seen = 0;
        repeat (20) begin
            cyc(1'b1);
            seen += int'(m_axis_tvalid);
        end
        chk("idle_tvalid", seen, 0);

        // sine quadrants
        g_acc  = '0;
        g_ftw  = 32'h4000_0000;
        g_poff = '0;
        g_wave = 2'd0;
        push(64);
        commit(32'h4000_0000, 0, 32'h1);
        hs = 0;
        got.delete();
        chk("lat_e0", m_axis_tvalid, 0);
        cyc(1'b1);
        chk("lat_e1", m_axis_tvalid, 0);
        cyc(1'b1);
        chk("lat_e2", m_axis_tvalid, 0);
        cyc(1'b1);
        chk("lat_e3", m_axis_tvalid, 1);
        repeat (8) cyc(1'b1);
        chk("sine_cnt8", sample_cnt, 8);
        for (int i = 0; i < 8; i++) chk("sine_tab", got[i], sine_tab[i % 4]);

        // backpressure
        repeat (5) cyc(1'b0);
        chk("stall_cnt", sample_cnt, 8);
        repeat (6) cyc(1'b1);
        chk("resume_cnt", sample_cnt, 14);

        // phase-continuous retune
        commit(32'h2000_0000, 0, 32'h1);
        keep(3);
        g_ftw = 32'h2000_0000;
        push(40);
        repeat (12) cyc(1'b1);

        // phase reset
        commit(32'h2000_0000, 0, 32'h9);
        keep(3);
        g_acc = '0;
        g_n   = 3;
        push(40);
        chk("pr_cnt0", sample_cnt, 0);
        repeat (3) cyc(1'b1);
        chk("pr_cnt3", sample_cnt, 3);
        chk("pr_first", $signed(m_axis_tdata), 25);
        repeat (9) cyc(1'b1);

        // disable drain timing
        commit(32'h2000_0000, 0, 32'h0);
        keep(3);
        chk("dis_e0", m_axis_tvalid, 1);
        cyc(1'b1);
        chk("dis_e1", m_axis_tvalid, 1);
        cyc(1'b1);
        chk("dis_e2", m_axis_tvalid, 1);
        cyc(1'b1);
        chk("dis_e3", m_axis_tvalid, 0);
        chk("dis_cnt", sample_cnt, g_n);
        repeat (4) cyc(1'b1);

        // re-enable from the held accumulator
        push(30);
        commit(32'h2000_0000, 0, 32'h1);
        repeat (13) cyc(1'b1);
        drain(1'b0);

        // square and saw
        run_cfg(32'h8000_0000, 0, 2'd2, 8, 1'b0);
        chk("sq0", got[0], 32767);
        chk("sq1", got[1], -32767);
        run_cfg(32'h8000_0000, 0, 2'd1, 8, 1'b0);
        chk("saw0", got[0], -32768);
        chk("saw1", got[1], 0);

        // randomized configurations with random backpressure
        for (int it = 0; it < 8; it++) begin
            run_cfg($urandom, $urandom, 2'($urandom_range(0, 3)), 60, 1'b1);
        end
        run_cfg($urandom, $urandom, 2'd3, 40, 1'b1);

        // reset mid-stream
        run_cfg(32'h1234_5678, 0, 2'd0, 6, 1'b0);
        exp_q.delete();
        g_acc  = '0;
        g_ftw  = 32'h4000_0000;
        g_poff = '0;
        g_wave = 2'd0;
        push(40);
        commit(32'h4000_0000, 0, 32'h9);
        repeat (6) cyc(1'b1);
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;
        ARESET   = 1'b0;
        hold_chk = 0;
        exp_q.delete();
        chk("mrst_tvalid", m_axis_tvalid, 0);
        chk("mrst_tdata", m_axis_tdata, 0);
        chk("mrst_cnt", sample_cnt, 0);
        seen = 0;
        repeat (6) begin
            cyc(1'b1);
            seen += int'(m_axis_tvalid);
        end
        chk("mrst_idle", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
